serial_addsub: RTL and testbench
================================

Name: serial_addsub

Overview:
- Parametrised successor to the 1-bit serial adder.
- Adds or subtracts two N-bit operands D bits per clock, LSB digit first, through an internal D-bit ripple slice and a carry flip-flop.
- Has a start/busy/done handshake, selectable add/sub mode, and a signed-overflow flag.
- Sits in the datapath wherever area matters more than latency; one operation is in flight at a time.

Parameters:
- N, 8: operand and result width in bits. Must be ≥ 2.
- D, 1: digit width processed per cycle. N mod D must equal 0, otherwise elaboration fails. D = N gives single-cycle compute.

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- rst, input, 1: reset, asynchronous, active-low (0 = reset).
- start, input, 1: request a new operation; sampled only in IDLE.
- sub, input, 1: 0 = a+b, 1 = a−b; sampled with start.
- a, input, N: operand A; sampled with start.
- b, input, N: operand B; sampled with start.
- busy, output, 1: high in RUN and DONE.
- done, output, 1: one-cycle pulse when the result becomes valid.
- sum, output, N: result; held stable from done until the next accepted start.
- cout, output, 1: final carry out of the MSB (for sub: 1 = no borrow).
- ovf, output, 1: signed overflow = carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (rst = 0, asynchronous):
  - state = IDLE; digit counter = 0; carry = 0; operand and result shift registers = 0.
  - Outputs: sum = 0, cout = 0, ovf = 0, busy = 0, done = 0.
- Reset asserted mid-operation aborts the operation immediately. No done pulse is produced.

State machine:
- IDLE:
  - busy = 0.
  - start = 1 at a rising edge: load A ← a, B ← (sub ? ~b : b), carry ← sub, counter ← 0, result register ← 0, go to RUN.
  - sum, cout, ovf keep their previous values until that load edge, then update as the result register shifts.
- RUN, one edge per digit:
  - slice computes {c_out, s[D-1:0]} = A[D-1:0] + B[D-1:0] + carry.
  - Result register shifts right by D, with s entering at the top.
  - A and B shift right by D, zero fill.
  - carry ← c_out; counter increments.
  - On the digit whose counter = N/D − 1, also capture the carry into the MSB for ovf, then go to DONE.
- DONE:
  - done = 1 and busy = 1 for exactly one cycle.
  - sum = result register; cout = carry; ovf latched. Go to IDLE.
- start is ignored in RUN and DONE; there is no queueing.
- start asserted in the IDLE cycle right after DONE is accepted normally.

Timing and counter:
- Latency: start accepted at edge k → done high during the cycle after edge k + N/D; next start can be accepted at edge k + N/D + 2.
- Counter width: clog2(N/D) + 1 bits.

Arithmetic:
- Modulo 2^N.
- Subtraction is two's complement via ~b plus carry-in = 1.
- cout and ovf are defined identically for D = 1 and D > 1; the result is bit-exact independent of D.

Optional Feature:
- SERIAL_ADDSUB_SAT_EN defined:
  - When ovf = 1 at DONE, sum is replaced by the signed saturation value.
  - Saturation value is 0111…1 if operand A's MSB was 0, and 1000…0 if it was 1.
  - The A MSB is captured at start.
  - ovf still reports 1; cout is unchanged.
  - Adds one N-bit mux on the sum output and a 1-bit sign register.
- Not defined: sum always wraps modulo 2^N; no saturation logic is present.

Test Plan:
- N=8, D=1, a=0x35, b=0x4A, sub=0, start → done 9 cycles after the start edge; sum=0x7F, cout=0, ovf=0; busy high throughout.
- N=8, D=1, a=0x70, b=0x20, sub=0 → sum=0x90, ovf=1, cout=0. With SERIAL_ADDSUB_SAT_EN: sum=0x7F, ovf=1.
- N=8, D=4, a=0x10, b=0x20, sub=1 → done 3 cycles after start; sum=0xF0, cout=0 (borrow), ovf=0. Repeat with D=1 and D=8: identical results.
- N=8, D=1, a=0xFF, b=0x01, sub=0 → sum=0x00, cout=1, ovf=0. Pulse start again in mid-RUN with other operands → ignored; result unchanged.
- Start an operation, drive rst low at cycle 3 of RUN → all outputs 0 immediately; no done; after release, a fresh start completes correctly.
- Back-to-back: start held high continuously with changing operands → one operation accepted per N/D + 2 cycles; each done pulse matches the operands sampled at its own start.

Source files
------------

// File: rtl/serial_addsub.sv
// Digit-serial adder/subtractor: D bits per clock, LSB digit first, start/busy/done handshake.
// Define SERIAL_ADDSUB_SAT_EN to saturate the result to the signed limit on overflow.
module serial_addsub #(
  parameter int N = 8,
  parameter int D = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         sub,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         ovf
);

  localparam int DIGITS = N / D;
  localparam int CW     = $clog2(DIGITS) + 1;

  if (N < 2 || (N % D) != 0) begin : g_bad_param
    $error("serial_addsub: N must be >= 2 and a multiple of D");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          carry;
  logic [N-1:0]  a_sr;
  logic [N-1:0]  b_sr;
  logic [N-1:0]  res;
  logic          ovf_q;
  logic [D:0]    slice;
  logic          cin_msb;

`ifdef SERIAL_ADDSUB_SAT_EN
  logic sign_q;

  function automatic logic signed [N-1:0] sat_val(input logic neg);
    sat_val = neg ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
  endfunction
`endif

  // Ripple slice over the current low digit of both operands
  always_comb begin
    slice   = {1'b0, a_sr[D-1:0]} + {1'b0, b_sr[D-1:0]} + {{D{1'b0}}, carry};
    // On the last digit, bit D-1 of the slice is the word MSB
    cin_msb = slice[D-1] ^ a_sr[D-1] ^ b_sr[D-1];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      carry <= 1'b0;
      a_sr  <= '0;
      b_sr  <= '0;
      res   <= '0;
      ovf_q <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
`ifdef SERIAL_ADDSUB_SAT_EN
      sign_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sr  <= a;
            b_sr  <= sub ? ~b : b;
            carry <= sub;
            cnt   <= '0;
            res   <= '0;
            ovf_q <= 1'b0;
            busy  <= 1'b1;
            state <= RUN;
`ifdef SERIAL_ADDSUB_SAT_EN
            sign_q <= a[N-1];
`endif
          end
        end
        RUN: begin
          res   <= (res >> D) | (N'(slice[D-1:0]) << (N - D));
          a_sr  <= a_sr >> D;
          b_sr  <= b_sr >> D;
          carry <= slice[D];
          cnt   <= cnt + CW'(1);
          if (cnt == CW'(DIGITS - 1)) begin
            ovf_q <= cin_msb ^ slice[D];
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign cout = carry;
  assign ovf  = ovf_q;
`ifdef SERIAL_ADDSUB_SAT_EN
  assign sum  = ovf_q ? sat_val(sign_q) : res;
`else
  assign sum  = res;
`endif

endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub: three instances (D = 1, 4, 8) share stimulus and are checked
// every cycle against an arithmetic model, plus directed literal expectations.
module tb_serial_addsub;

  logic        clk;
  logic        rst;
  logic        start;
  logic        sub;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [2:0]  busy_w;
  logic [2:0]  done_w;
  logic [2:0]  cout_w;
  logic [2:0]  ovf_w;
  logic [23:0] sum_all;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;
  int lat [3];

  serial_addsub #(.N(8), .D(1)) u_d1 (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy_w[0]), .done(done_w[0]), .sum(sum_all[7:0]), .cout(cout_w[0]), .ovf(ovf_w[0]));
  serial_addsub #(.N(8), .D(4)) u_d4 (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy_w[1]), .done(done_w[1]), .sum(sum_all[15:8]), .cout(cout_w[1]), .ovf(ovf_w[1]));
  serial_addsub #(.N(8), .D(8)) u_d8 (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy_w[2]), .done(done_w[2]), .sum(sum_all[23:16]), .cout(cout_w[2]), .ovf(ovf_w[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int dg(input int i);
    dg = (i == 0) ? 8 : (i == 1) ? 2 : 1;
  endfunction

  // Returns {cout, ovf, sum} for an 8-bit add/sub from plain integer arithmetic
  function automatic logic [9:0] model_op(input logic [7:0] x, input logic [7:0] y, input logic s);
    int         sx, sy, r;
    logic       co, ov;
    logic [7:0] res;
    sx  = int'($signed(x));
    sy  = int'($signed(y));
    r   = s ? (sx - sy) : (sx + sy);
    ov  = (r > 127) || (r < -128);
    co  = s ? (int'(x) >= int'(y)) : ((int'(x) + int'(y)) > 255);
    res = s ? (x - y) : (x + y);
`ifdef SERIAL_ADDSUB_SAT_EN
    if (ov) res = x[7] ? 8'h80 : 8'h7F;
`endif
    model_op = {co, ov, res};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: cycles left until each instance is idle again, plus the held result
  int         m_left [3] = '{0, 0, 0};
  logic [7:0] m_sum  [3] = '{8'h00, 8'h00, 8'h00};
  logic       m_cout [3] = '{1'b0, 1'b0, 1'b0};
  logic       m_ovf  [3] = '{1'b0, 1'b0, 1'b0};

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        m_left[i] <= 0;
        m_sum[i]  <= 8'h00;
        m_cout[i] <= 1'b0;
        m_ovf[i]  <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (m_left[i] == 0) begin
          if (start) begin
            m_left[i] <= dg(i) + 1;
            {m_cout[i], m_ovf[i], m_sum[i]} <= model_op(a, b, sub);
          end
        end else begin
          m_left[i] <= m_left[i] - 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("busy_d%0d", i), 32'(busy_w[i]), 32'(m_left[i] != 0));
        chk($sformatf("done_d%0d", i), 32'(done_w[i]), 32'(m_left[i] == 1));
        if (m_left[i] <= 1) begin
          chk($sformatf("sum_d%0d", i), 32'(sum_all[i*8 +: 8]), 32'(m_sum[i]));
          chk($sformatf("cout_d%0d", i), 32'(cout_w[i]), 32'(m_cout[i]));
          chk($sformatf("ovf_d%0d", i), 32'(ovf_w[i]), 32'(m_ovf[i]));
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Launch one operation; optionally re-pulse start mid-run with other operands
  task automatic do_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic ts, input bit pulse);
    bit got;
    @(posedge clk); #2;
    a = ta; b = tb_v; sub = ts; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    for (int i = 0; i < 3; i++) lat[i] = 0;
    got = 1'b0;
    for (int n = 1; n <= 30 && !got; n++) begin
      if (n > 1) begin
        @(posedge clk); #2;
      end
      if (pulse && n == 4) begin
        a = 8'h12; b = 8'h34; sub = 1'b1; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      for (int i = 0; i < 3; i++)
        if (done_w[i] && lat[i] == 0) lat[i] = n;
      if (done_w[0]) got = 1'b1;
    end
    start = 1'b0;
    if (!got) chk("timeout_done", 32'd0, 32'd1);
  endtask

  logic [7:0] exp_sat;
  int         dcount [3];

  initial begin
    rst = 1'b0; start = 1'b0; sub = 1'b0; a = 8'h00; b = 8'h00;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_busy", 32'(busy_w), 32'd0);
    chk("rst_done", 32'(done_w), 32'd0);
    chk("rst_sum",  32'(sum_all), 32'd0);
    chk("rst_cout", 32'(cout_w), 32'd0);
    chk("rst_ovf",  32'(ovf_w), 32'd0);
    rst = 1'b1;
    chk_en = 1'b1;
    idle(2);

    // 0x35 + 0x4A
    do_op(8'h35, 8'h4A, 1'b0, 1'b0);
    chk("t1_lat_d1", 32'(lat[0]), 32'd9);
    chk("t1_lat_d4", 32'(lat[1]), 32'd3);
    chk("t1_lat_d8", 32'(lat[2]), 32'd2);
    chk("t1_sum", 32'(sum_all[7:0]), 32'h7F);
    chk("t1_cout", 32'(cout_w[0]), 32'd0);
    chk("t1_ovf", 32'(ovf_w[0]), 32'd0);
    chk("t1_busy", 32'(busy_w[0]), 32'd1);

    // 0x70 + 0x20 overflows positive
`ifdef SERIAL_ADDSUB_SAT_EN
    exp_sat = 8'h7F;
`else
    exp_sat = 8'h90;
`endif
    do_op(8'h70, 8'h20, 1'b0, 1'b0);
    chk("t2_sum", 32'(sum_all), {8'h00, exp_sat, exp_sat, exp_sat});
    chk("t2_ovf", 32'(ovf_w), 32'h7);
    chk("t2_cout", 32'(cout_w), 32'h0);

    // 0x10 - 0x20 borrows; identical for every digit width
    do_op(8'h10, 8'h20, 1'b1, 1'b0);
    chk("t3_sum", 32'(sum_all), 32'h00F0F0F0);
    chk("t3_cout", 32'(cout_w), 32'h0);
    chk("t3_ovf", 32'(ovf_w), 32'h0);

    // 0xFF + 0x01 with a start pulse during RUN
    do_op(8'hFF, 8'h01, 1'b0, 1'b1);
    chk("t4_sum", 32'(sum_all[7:0]), 32'h00);
    chk("t4_cout", 32'(cout_w[0]), 32'd1);
    chk("t4_ovf", 32'(ovf_w[0]), 32'd0);
    idle(3);
    chk("t4_hold_sum", 32'(sum_all[7:0]), 32'h00);
    chk("t4_hold_cout", 32'(cout_w[0]), 32'd1);
    idle(8);

    // -128 - 1 overflows negative
`ifdef SERIAL_ADDSUB_SAT_EN
    exp_sat = 8'h80;
`else
    exp_sat = 8'h7F;
`endif
    do_op(8'h80, 8'h01, 1'b1, 1'b0);
    chk("t5_sum", 32'(sum_all[7:0]), 32'(exp_sat));
    chk("t5_cout", 32'(cout_w[0]), 32'd1);
    chk("t5_ovf", 32'(ovf_w[0]), 32'd1);

    // Asynchronous reset in the middle of RUN
    @(posedge clk); #2;
    a = 8'hC3; b = 8'h11; sub = 1'b0; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("abort_busy", 32'(busy_w), 32'd0);
    chk("abort_done", 32'(done_w), 32'd0);
    chk("abort_sum",  32'(sum_all), 32'd0);
    chk("abort_cout", 32'(cout_w), 32'd0);
    chk("abort_ovf",  32'(ovf_w), 32'd0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    idle(12);
    do_op(8'h5A, 8'h3C, 1'b1, 1'b0);
    chk("t6_sum", 32'(sum_all), 32'h001E1E1E);
    chk("t6_cout", 32'(cout_w), 32'h7);
    chk("t6_ovf", 32'(ovf_w), 32'h0);
    idle(3);

    // start held high with operands changing every cycle
    for (int i = 0; i < 3; i++) dcount[i] = 0;
    a = 8'h05; b = 8'h03; sub = 1'b0; start = 1'b1;
    for (int j = 0; j < 40; j++) begin
      @(posedge clk); #2;
      for (int i = 0; i < 3; i++)
        if (done_w[i]) dcount[i]++;
      if (j >= 29) begin
        start = 1'b0;
      end else begin
        a   = 8'((j + 1) * 37 + 5);
        b   = 8'((j + 1) * 91 + 3);
        sub = j[0];
      end
    end
    chk("b2b_dones_d1", 32'(dcount[0]), 32'd3);
    chk("b2b_dones_d4", 32'(dcount[1]), 32'd8);
    chk("b2b_dones_d8", 32'(dcount[2]), 32'd10);
    idle(4);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
